// File: rtl/vcpu32_pkg.sv
// Shared VCPU-32 pipeline definitions: datapath widths, operand-select codes and
// the opaque execute-control field type.
package vcpu32_pkg;

    localparam int VCPU_DATA_W = 32;
    localparam int VCPU_AW     = 4;
    localparam int VCPU_CTL_W  = 16;

    typedef enum logic [1:0] {
        SEL_RF,
        SEL_EX,
        SEL_WB1,
        SEL_WB2
    } opsel_e;

    typedef logic [VCPU_CTL_W-1:0] ctl_t;

endpackage

// File: rtl/operand_fetch_stage_scoreboard.sv
// Per-register 2-bit pending-write counters for the operand fetch interlock.
// One increment port (issue) and two decrement ports (writeback), net change per cycle.
module scoreboard_16x2
    import vcpu32_pkg::*;
#(
    parameter int AW = VCPU_AW
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_inc_en,
    input  logic [AW-1:0]              i_inc_addr,
    input  logic                       i_dec1_en,
    input  logic [AW-1:0]              i_dec1_addr,
    input  logic                       i_dec2_en,
    input  logic [AW-1:0]              i_dec2_addr,
    output logic [(1<<AW)-1:0][1:0]    o_pend
);

    localparam int NREG = 1 << AW;

    logic [NREG-1:0][1:0] r_pend;
    logic [NREG-1:0][1:0] w_pend_nxt;

    // Decrements below zero are stray writebacks; the counter floors at 0.
    function automatic logic [1:0] pend_next(
        input logic [1:0] cur,
        input logic       inc,
        input logic [1:0] dec
    );
        logic [2:0] up;
        up = {1'b0, cur} + {2'b00, inc};
        if (up <= {1'b0, dec}) return 2'd0;
        up = up - {1'b0, dec};
        if (up > 3'd3) return 2'd3;
        return up[1:0];
    endfunction

    always_comb begin
        w_pend_nxt = r_pend;
        for (int r = 0; r < NREG; r++) begin
            w_pend_nxt[r] = pend_next(
                r_pend[r],
                i_inc_en && (i_inc_addr == AW'(r)),
                {1'b0, i_dec1_en && (i_dec1_addr == AW'(r))} +
                {1'b0, i_dec2_en && (i_dec2_addr == AW'(r))});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    assign o_pend = r_pend;

endmodule

// File: rtl/operand_fetch_stage.sv
// VCPU-32 operand fetch: register-file read, RAW interlock via scoreboard and a
// valid/ready output register. Define OPERAND_BYPASS_EN to enable ex/wb forwarding.
module operand_fetch_stage
    import vcpu32_pkg::*;
#(
    parameter int DATA_W = VCPU_DATA_W,
    parameter int AW     = VCPU_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [AW-1:0]     id_ra,
    input  logic [AW-1:0]     id_rb,
    input  logic [AW-1:0]     id_rc,
    input  logic              id_use_a,
    input  logic              id_use_b,
    input  logic              id_use_c,
    input  logic [AW-1:0]     id_rd,
    input  logic              id_rd_we,
    input  ctl_t              id_ctl,
    output logic [AW-1:0]     rf_raddr_1,
    output logic [AW-1:0]     rf_raddr_2,
    output logic [AW-1:0]     rf_raddr_3,
    input  logic [DATA_W-1:0] rf_rdata_1,
    input  logic [DATA_W-1:0] rf_rdata_2,
    input  logic [DATA_W-1:0] rf_rdata_3,
    input  logic              ex_fwd_valid,
    input  logic [AW-1:0]     ex_fwd_rd,
    input  logic [DATA_W-1:0] ex_fwd_data,
    input  logic              wb_we_1,
    input  logic [AW-1:0]     wb_addr_1,
    input  logic [DATA_W-1:0] wb_data_1,
    input  logic              wb_we_2,
    input  logic [AW-1:0]     wb_addr_2,
    input  logic [DATA_W-1:0] wb_data_2,
    output logic              of_valid,
    input  logic              of_ready,
    output logic [DATA_W-1:0] of_a,
    output logic [DATA_W-1:0] of_b,
    output logic [DATA_W-1:0] of_c,
    output logic [AW-1:0]     of_rd,
    output logic              of_rd_we,
    output ctl_t              of_ctl
);

    localparam int NREG = 1 << AW;

    logic [NREG-1:0][1:0] w_pend;
    opsel_e               w_sel_a, w_sel_b, w_sel_c;
    logic [DATA_W-1:0]    w_op_a, w_op_b, w_op_c;
    logic                 w_hazard, w_full_cnt, w_stall_out, w_accept;

    logic                 r_vld_p1;
    logic [DATA_W-1:0]    r_a_p1, r_b_p1, r_c_p1;
    logic [AW-1:0]        r_rd_p1;
    logic                 r_rd_we_p1;
    ctl_t                 r_ctl_p1;

    assign rf_raddr_1 = id_ra;
    assign rf_raddr_2 = id_rb;
    assign rf_raddr_3 = id_rc;

`ifdef OPERAND_BYPASS_EN
    // Youngest result wins: execute, then writeback port 1, then port 2.
    function automatic opsel_e pick_src(
        input logic [AW-1:0] src,
        input logic          ex_v,
        input logic [AW-1:0] ex_rd,
        input logic          we1,
        input logic [AW-1:0] a1,
        input logic          we2,
        input logic [AW-1:0] a2
    );
        if (ex_v && (ex_rd == src)) return SEL_EX;
        if (we1 && (a1 == src))     return SEL_WB1;
        if (we2 && (a2 == src))     return SEL_WB2;
        return SEL_RF;
    endfunction

    function automatic logic [DATA_W-1:0] mux_op(
        input opsel_e            sel,
        input logic [DATA_W-1:0] rf,
        input logic [DATA_W-1:0] ex,
        input logic [DATA_W-1:0] wb1,
        input logic [DATA_W-1:0] wb2
    );
        case (sel)
            SEL_EX:  return ex;
            SEL_WB1: return wb1;
            SEL_WB2: return wb2;
            default: return rf;
        endcase
    endfunction

    assign w_sel_a = pick_src(id_ra, ex_fwd_valid, ex_fwd_rd, wb_we_1, wb_addr_1, wb_we_2, wb_addr_2);
    assign w_sel_b = pick_src(id_rb, ex_fwd_valid, ex_fwd_rd, wb_we_1, wb_addr_1, wb_we_2, wb_addr_2);
    assign w_sel_c = pick_src(id_rc, ex_fwd_valid, ex_fwd_rd, wb_we_1, wb_addr_1, wb_we_2, wb_addr_2);

    assign w_op_a = mux_op(w_sel_a, rf_rdata_1, ex_fwd_data, wb_data_1, wb_data_2);
    assign w_op_b = mux_op(w_sel_b, rf_rdata_2, ex_fwd_data, wb_data_1, wb_data_2);
    assign w_op_c = mux_op(w_sel_c, rf_rdata_3, ex_fwd_data, wb_data_1, wb_data_2);
`else
    logic w_unused_fwd;

    assign w_sel_a = SEL_RF;
    assign w_sel_b = SEL_RF;
    assign w_sel_c = SEL_RF;

    assign w_op_a = rf_rdata_1;
    assign w_op_b = rf_rdata_2;
    assign w_op_c = rf_rdata_3;

    assign w_unused_fwd = ^{ex_fwd_valid, ex_fwd_rd, ex_fwd_data, wb_data_1, wb_data_2};
`endif

    // A forwarded source is satisfied regardless of how many writes are pending.
    assign w_hazard = (id_use_a && (w_pend[id_ra] != 2'd0) && (w_sel_a == SEL_RF)) ||
                      (id_use_b && (w_pend[id_rb] != 2'd0) && (w_sel_b == SEL_RF)) ||
                      (id_use_c && (w_pend[id_rc] != 2'd0) && (w_sel_c == SEL_RF));

    assign w_full_cnt  = id_rd_we && (w_pend[id_rd] == 2'd3);
    assign w_stall_out = r_vld_p1 && !of_ready;
    assign id_ready    = !w_hazard && !w_stall_out && !w_full_cnt;
    assign w_accept    = id_valid && id_ready;

    scoreboard_16x2 #(
        .AW (AW)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_inc_en    (w_accept && id_rd_we),
        .i_inc_addr  (id_rd),
        .i_dec1_en   (wb_we_1),
        .i_dec1_addr (wb_addr_1),
        .i_dec2_en   (wb_we_2),
        .i_dec2_addr (wb_addr_2),
        .o_pend      (w_pend)
    );

    // ---- p0 -> p1: operand register feeding execute ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1   <= 1'b0;
            r_a_p1     <= '0;
            r_b_p1     <= '0;
            r_c_p1     <= '0;
            r_rd_p1    <= '0;
            r_rd_we_p1 <= 1'b0;
            r_ctl_p1   <= '0;
        end else if (w_accept) begin
            r_vld_p1   <= 1'b1;
            r_a_p1     <= w_op_a;
            r_b_p1     <= w_op_b;
            r_c_p1     <= w_op_c;
            r_rd_p1    <= id_rd;
            r_rd_we_p1 <= id_rd_we;
            r_ctl_p1   <= id_ctl;
        end else if (of_ready) begin
            r_vld_p1   <= 1'b0;
        end
    end

    assign of_valid = r_vld_p1;
    assign of_a     = r_a_p1;
    assign of_b     = r_b_p1;
    assign of_c     = r_c_p1;
    assign of_rd    = r_rd_p1;
    assign of_rd_we = r_rd_we_p1;
    assign of_ctl   = r_ctl_p1;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_operand_fetch_stage;

`ifdef OPERAND_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_ready;
    logic [3:0]  id_ra, id_rb, id_rc, id_rd;
    logic        id_use_a, id_use_b, id_use_c, id_rd_we;
    logic [15:0] id_ctl;
    logic [3:0]  rf_raddr_1, rf_raddr_2, rf_raddr_3;
    logic [31:0] rf_rdata_1, rf_rdata_2, rf_rdata_3;
    logic        ex_fwd_valid;
    logic [3:0]  ex_fwd_rd;
    logic [31:0] ex_fwd_data;
    logic        wb_we_1, wb_we_2;
    logic [3:0]  wb_addr_1, wb_addr_2;
    logic [31:0] wb_data_1, wb_data_2;
    logic        of_valid, of_ready, of_rd_we;
    logic [31:0] of_a, of_b, of_c;
    logic [3:0]  of_rd;
    logic [15:0] of_ctl;

    logic [31:0] rf [16];

    assign rf_rdata_1 = rf[rf_raddr_1];
    assign rf_rdata_2 = rf[rf_raddr_2];
    assign rf_rdata_3 = rf[rf_raddr_3];

    operand_fetch_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_ra(id_ra), .id_rb(id_rb), .id_rc(id_rc),
        .id_use_a(id_use_a), .id_use_b(id_use_b), .id_use_c(id_use_c),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_ctl(id_ctl),
        .rf_raddr_1(rf_raddr_1), .rf_raddr_2(rf_raddr_2), .rf_raddr_3(rf_raddr_3),
        .rf_rdata_1(rf_rdata_1), .rf_rdata_2(rf_rdata_2), .rf_rdata_3(rf_rdata_3),
        .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
        .wb_we_1(wb_we_1), .wb_addr_1(wb_addr_1), .wb_data_1(wb_data_1),
        .wb_we_2(wb_we_2), .wb_addr_2(wb_addr_2), .wb_data_2(wb_data_2),
        .of_valid(of_valid), .of_ready(of_ready),
        .of_a(of_a), .of_b(of_b), .of_c(of_c),
        .of_rd(of_rd), .of_rd_we(of_rd_we), .of_ctl(of_ctl)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int          m_pend [16];
    logic        m_vld;
    logic [31:0] m_a, m_b, m_c;
    logic [3:0]  m_rd;
    logic        m_rd_we;
    logic [15:0] m_ctl;
    logic [3:0]  q_inflight [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_pend[i] = 0;
        m_vld = 1'b0; m_a = '0; m_b = '0; m_c = '0;
        m_rd = '0; m_rd_we = 1'b0; m_ctl = '0;
        q_inflight.delete();
    endtask

    function automatic bit fwdable(input logic [3:0] s);
        return BYP && ((ex_fwd_valid && ex_fwd_rd == s) ||
                       (wb_we_1 && wb_addr_1 == s) || (wb_we_2 && wb_addr_2 == s));
    endfunction

    function automatic logic [31:0] opval(input logic [3:0] s);
        if (BYP && ex_fwd_valid && ex_fwd_rd == s) return ex_fwd_data;
        if (BYP && wb_we_1 && wb_addr_1 == s)      return wb_data_1;
        if (BYP && wb_we_2 && wb_addr_2 == s)      return wb_data_2;
        return rf[s];
    endfunction

    function automatic bit exp_ready();
        bit hz, full, stall;
        hz = (id_use_a && m_pend[id_ra] != 0 && !fwdable(id_ra)) ||
             (id_use_b && m_pend[id_rb] != 0 && !fwdable(id_rb)) ||
             (id_use_c && m_pend[id_rc] != 0 && !fwdable(id_rc));
        full  = id_rd_we && (m_pend[id_rd] == 3);
        stall = m_vld && !of_ready;
        return !(hz || full || stall);
    endfunction

    task automatic idle();
        id_valid = 1'b0; id_ra = '0; id_rb = '0; id_rc = '0; id_rd = '0;
        id_use_a = 1'b0; id_use_b = 1'b0; id_use_c = 1'b0; id_rd_we = 1'b0; id_ctl = '0;
        ex_fwd_valid = 1'b0; ex_fwd_rd = '0; ex_fwd_data = '0;
        wb_we_1 = 1'b0; wb_addr_1 = '0; wb_data_1 = '0;
        wb_we_2 = 1'b0; wb_addr_2 = '0; wb_data_2 = '0;
        of_ready = 1'b1;
    endtask

    task automatic set_instr(input logic [3:0] ra, input logic ua, input logic [3:0] rb,
                             input logic ub, input logic [3:0] rd, input logic we);
        id_valid = 1'b1; id_ra = ra; id_use_a = ua; id_rb = rb; id_use_b = ub;
        id_rc = 4'd0; id_use_c = 1'b0; id_rd = rd; id_rd_we = we; id_ctl = 16'($urandom);
    endtask

    task automatic wb_off();
        wb_we_1 = 1'b0; wb_we_2 = 1'b0; ex_fwd_valid = 1'b0;
    endtask

    // One clock: combinational checks before the edge, register checks after.
    task automatic cycle();
        bit er, acc;
        int np [16];
        logic [31:0] na, nb, nc;
        #1;
        er = exp_ready();
        if (id_valid) chk("id_ready", 32'(id_ready), 32'(er));
        chk("rf_raddr", {20'd0, rf_raddr_1, rf_raddr_2, rf_raddr_3}, {20'd0, id_ra, id_rb, id_rc});
        acc = id_valid && er;
        na = opval(id_ra); nb = opval(id_rb); nc = opval(id_rc);
        for (int r = 0; r < 16; r++) begin
            np[r] = m_pend[r] + ((acc && id_rd_we && int'(id_rd) == r) ? 1 : 0)
                              - ((wb_we_1 && int'(wb_addr_1) == r) ? 1 : 0)
                              - ((wb_we_2 && int'(wb_addr_2) == r) ? 1 : 0);
            if (np[r] < 0) np[r] = 0;
        end
        if (acc && id_rd_we) q_inflight.push_back(id_rd);
        @(posedge clk);
        @(negedge clk);
        if (wb_we_2) rf[wb_addr_2] = wb_data_2;
        if (wb_we_1) rf[wb_addr_1] = wb_data_1;
        m_pend = np;
        if (acc) begin
            m_vld = 1'b1; m_a = na; m_b = nb; m_c = nc;
            m_rd = id_rd; m_rd_we = id_rd_we; m_ctl = id_ctl;
        end else if (of_ready) begin
            m_vld = 1'b0;
        end
        chk("of_valid", 32'(of_valid), 32'(m_vld));
        chk("of_a", of_a, m_a);
        chk("of_b", of_b, m_b);
        chk("of_c", of_c, m_c);
        chk("of_rd", 32'(of_rd), 32'(m_rd));
        chk("of_rd_we", 32'(of_rd_we), 32'(m_rd_we));
        chk("of_ctl", 32'(of_ctl), 32'(m_ctl));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_of_valid"}, 32'(of_valid), 32'd0);
        chk({tag, "_of_a"}, of_a, 32'd0);
        chk({tag, "_of_b"}, of_b, 32'd0);
        chk({tag, "_of_c"}, of_c, 32'd0);
        chk({tag, "_of_rd"}, 32'(of_rd), 32'd0);
        chk({tag, "_of_rd_we"}, 32'(of_rd_we), 32'd0);
        chk({tag, "_of_ctl"}, 32'(of_ctl), 32'd0);
    endtask

    task automatic pin_ready(input string nm, input logic exp);
        #1;
        chk(nm, 32'(id_ready), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        for (int i = 0; i < 16; i++) rf[i] = 32'h100 + i;
        rf[0] = 32'h00C0FFEE;
        rf[2] = 32'd5;
        rf[3] = 32'd7;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_outputs("reset");
        chk("reset_id_ready", 32'(id_ready), 32'd1);

        // r1 = r2 op r3
        set_instr(4'd2, 1'b1, 4'd3, 1'b1, 4'd1, 1'b1);
        cycle();
        chk("basic_of_valid", 32'(of_valid), 32'd1);
        chk("basic_of_a", of_a, 32'd5);
        chk("basic_of_b", of_b, 32'd7);
        chk("basic_of_rd", 32'(of_rd), 32'd1);
        set_instr(4'd1, 1'b1, 4'd0, 1'b0, 4'd8, 1'b0);
        pin_ready("pend_r1_hazard", 1'b0);
        cycle();
        wb_we_1 = 1'b1; wb_addr_1 = 4'd1; wb_data_1 = 32'h55;
        cycle();
        wb_off();
        cycle();
        chk("r1_after_wb_of_a", of_a, 32'h55);

        // r4 producer, dependent reader, execute forward then writeback
        set_instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1);
        cycle();
        set_instr(4'd4, 1'b1, 4'd0, 1'b0, 4'd9, 1'b0);
        ex_fwd_valid = 1'b1; ex_fwd_rd = 4'd4; ex_fwd_data = 32'h1234;
        cycle();
        wb_off();
        repeat (3) cycle();
        wb_we_1 = 1'b1; wb_addr_1 = 4'd4; wb_data_1 = 32'h4444;
        cycle();
        wb_off();
        cycle();
        chk("r4_final_of_a", of_a, 32'h4444);
        chk("r4_final_of_valid", 32'(of_valid), 32'd1);

        // two writes pending on r6, both writeback ports hit r6 together
        set_instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1);
        repeat (2) cycle();
        set_instr(4'd6, 1'b1, 4'd0, 1'b0, 4'd10, 1'b0);
        wb_we_1 = 1'b1; wb_addr_1 = 4'd6; wb_data_1 = 32'hA;
        wb_we_2 = 1'b1; wb_addr_2 = 4'd6; wb_data_2 = 32'hB;
        cycle();
        wb_off();
        pin_ready("r6_double_dec_ready", 1'b1);
        cycle();
        chk("r6_port1_prio_of_a", of_a, 32'hA);

        // counter saturation on r7
        set_instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1);
        repeat (3) cycle();
        pin_ready("r7_full_block", 1'b0);
        cycle();
        wb_we_1 = 1'b1; wb_addr_1 = 4'd7; wb_data_1 = 32'h70;
        pin_ready("r7_full_during_wb", 1'b0);
        cycle();
        wb_off();
        pin_ready("r7_after_wb_ready", 1'b1);
        cycle();

        // backpressure: outputs hold, scoreboard keeps draining
        of_ready = 1'b0;
        set_instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd11, 1'b1);
        wb_we_1 = 1'b1; wb_addr_1 = 4'd7; wb_data_1 = 32'h71;
        wb_we_2 = 1'b1; wb_addr_2 = 4'd7; wb_data_2 = 32'h72;
        for (int k = 0; k < 4; k++) begin
            pin_ready("bp_id_ready", 1'b0);
            cycle();
            wb_off();
            chk("bp_of_valid", 32'(of_valid), 32'd1);
            chk("bp_of_a", of_a, 32'h00C0FFEE);
            chk("bp_of_rd", 32'(of_rd), 32'd7);
        end
        of_ready = 1'b1;
        set_instr(4'd7, 1'b1, 4'd0, 1'b0, 4'd12, 1'b0);
        pin_ready("bp_r7_still_pending", 1'b0);
        cycle();
        wb_we_1 = 1'b1; wb_addr_1 = 4'd7; wb_data_1 = 32'h73;
        cycle();
        wb_off();
        pin_ready("bp_r7_drained", 1'b1);
        cycle();

        // asynchronous reset mid-operation
        set_instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1);
        repeat (2) cycle();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        set_instr(4'd5, 1'b1, 4'd0, 1'b0, 4'd13, 1'b0);
        pin_ready("post_reset_r5_ready", 1'b1);
        cycle();
        wb_we_1 = 1'b1; wb_addr_1 = 4'd5; wb_data_1 = 32'h50;
        cycle();
        wb_off();
        pin_ready("post_reset_sat_ready", 1'b1);
        cycle();

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            id_valid = ($urandom_range(0, 9) < 8);
            id_ra = 4'($urandom_range(0, 7));
            id_rb = 4'($urandom_range(0, 7));
            id_rc = 4'($urandom_range(0, 7));
            id_use_a = 1'($urandom_range(0, 1));
            id_use_b = 1'($urandom_range(0, 1));
            id_use_c = 1'($urandom_range(0, 1));
            id_rd = 4'($urandom_range(0, 7));
            id_rd_we = 1'($urandom_range(0, 1));
            id_ctl = 16'($urandom);
            of_ready = ($urandom_range(0, 3) != 0);
            ex_fwd_valid = ($urandom_range(0, 3) == 0);
            ex_fwd_rd = 4'($urandom_range(0, 7));
            ex_fwd_data = $urandom;
            wb_we_1 = 1'b0;
            wb_addr_1 = 4'($urandom_range(0, 7));
            if (q_inflight.size() > 0 && $urandom_range(0, 9) < 5) begin
                wb_we_1 = 1'b1; wb_addr_1 = q_inflight.pop_front();
            end else if ($urandom_range(0, 19) == 0) begin
                wb_we_1 = 1'b1;
            end
            wb_data_1 = $urandom;
            wb_we_2 = 1'b0;
            wb_addr_2 = 4'($urandom_range(0, 7));
            if (q_inflight.size() > 0 && $urandom_range(0, 9) < 3) begin
                wb_we_2 = 1'b1; wb_addr_2 = q_inflight.pop_front();
            end else if ($urandom_range(0, 19) == 0) begin
                wb_we_2 = 1'b1;
            end
            wb_data_2 = $urandom;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
